// File: rtl/keypad_pkg.sv
// keypad_pkg: shared states, key/command constants and helpers for keypad_code_entry
package keypad_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, EMIT, LOCKOUT} state_e;
  localparam logic [3:0] KEY_ARM     = 4'hA;
  localparam logic [3:0] KEY_DISARM  = 4'hB;
  localparam logic [3:0] KEY_CLR     = 4'hC;
  localparam logic [3:0] CODE_ARM    = 4'b0011;
  localparam logic [3:0] CODE_DISARM = 4'b1100;
  localparam logic [3:0] CODE_NONE   = 4'b0000;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    return m > c ? m : c;
  endfunction
  // PIN with its last digit bumped by one, wrapping 9 back to 0
  function automatic logic [31:0] duress_pin(input logic [31:0] pin);
    return {pin[31:4], pin[3:0] == 4'd9 ? 4'd0 : pin[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/keypad_code_entry_timer.sv
// keypad_timer: ENA-qualified loadable down-counter; expired while the count is zero
module keypad_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ena,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk)
    if (ena) cnt_q <= !reset_n ? '0 : cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/keypad_code_entry.sv
// keypad_code_entry: PIN entry, check, command pulse and failure lockout for the alarm keypad bus.
// Define KEYPAD_DURESS_EN to accept the duress PIN (last digit + 1) on DISARM and raise duress.
module keypad_code_entry
  import keypad_pkg::*;
#(
  parameter int          PIN_DIGITS  = 4,
  parameter logic [31:0] PIN_CODE    = 32'h0000_1234,
  parameter int          TIMEOUT_CYC = 200,
  parameter int          PULSE_CYC   = 4,
  parameter int          MAX_FAILS   = 3,
  parameter int          LOCKOUT_CYC = 1000
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               ENA,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  output logic [3:0]                         keypad,
  output logic                               entry_busy,
  output logic                               locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_cnt,
  output logic                               duress
);
  localparam int BW = 4 * PIN_DIGITS;
  localparam int CW = $clog2(PIN_DIGITS + 2);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(max3(TIMEOUT_CYC, PULSE_CYC, LOCKOUT_CYC) + 1);
  localparam logic [BW-1:0] PIN    = PIN_CODE[BW-1:0];
  localparam logic [CW-1:0] D_FULL = CW'(PIN_DIGITS);
  localparam logic [CW-1:0] D_OVF  = CW'(PIN_DIGITS + 1);
  localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAILS);
  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            disarm_q, disarm_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [3:0]      keypad_q, keypad_d;
  logic            busy_q, busy_d;
  logic            locked_q, locked_d;
  logic            duress_q, duress_d;
  logic            tmr_load, tmr_exp;
  logic [TW-1:0]   tmr_val;
  logic            is_digit, match, dmatch;
  assign is_digit = key_code <= 4'd9;
  assign match    = dcnt_q == D_FULL && buf_q == PIN;
`ifdef KEYPAD_DURESS_EN
  localparam logic [31:0]   DPIN_FULL = duress_pin(PIN_CODE);
  localparam logic [BW-1:0] DPIN      = DPIN_FULL[BW-1:0];
  assign dmatch = disarm_q && dcnt_q == D_FULL && buf_q == DPIN;
`else
  assign dmatch = 1'b0;
`endif
  keypad_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .ena      (ENA),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    dcnt_d   = dcnt_q;
    disarm_d = disarm_q;
    fail_d   = fail_q;
    duress_d = duress_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE:
        if (key_valid && is_digit) begin
          buf_d    = BW'(key_code);
          dcnt_d   = CW'(1);
          state_d  = COLLECT;
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYC - 1);
        end
      COLLECT:
        if (key_valid) begin
          // any strobe restarts the idle window, winning over a same-cycle expiry
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYC - 1);
          if (is_digit) begin
            buf_d  = (buf_q << 4) | BW'(key_code);
            dcnt_d = dcnt_q == D_OVF ? dcnt_q : dcnt_q + 1'b1;
          end else if (key_code == KEY_CLR) begin
            buf_d   = '0;
            dcnt_d  = '0;
            state_d = IDLE;
          end else if (key_code == KEY_ARM || key_code == KEY_DISARM) begin
            disarm_d = key_code == KEY_DISARM;
            state_d  = CHECK;
          end
        end else if (tmr_exp) begin
          buf_d   = '0;
          dcnt_d  = '0;
          state_d = IDLE;
        end
      CHECK: begin
        buf_d  = '0;
        dcnt_d = '0;
        if (match || dmatch) begin
          fail_d   = '0;
          duress_d = duress_q | (dmatch && !match);
          state_d  = EMIT;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYC - 1);
        end else begin
          fail_d   = fail_q + 1'b1;
          state_d  = fail_d == F_MAX ? LOCKOUT : IDLE;
          tmr_load = fail_d == F_MAX;
          tmr_val  = TW'(LOCKOUT_CYC - 1);
        end
      end
      EMIT:
        if (tmr_exp) state_d = IDLE;
      LOCKOUT:
        if (tmr_exp) begin
          fail_d  = '0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
    keypad_d = state_d == EMIT ? (disarm_q ? CODE_DISARM : CODE_ARM) : CODE_NONE;
    busy_d   = state_d == COLLECT || state_d == CHECK || state_d == EMIT;
    locked_d = state_d == LOCKOUT;
  end
  always_ff @(posedge clk)
    if (ENA) begin
      if (!reset_n) begin
        state_q  <= IDLE;
        buf_q    <= '0;
        dcnt_q   <= '0;
        disarm_q <= 1'b0;
        fail_q   <= '0;
        keypad_q <= CODE_NONE;
        busy_q   <= 1'b0;
        locked_q <= 1'b0;
        duress_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        buf_q    <= buf_d;
        dcnt_q   <= dcnt_d;
        disarm_q <= disarm_d;
        fail_q   <= fail_d;
        keypad_q <= keypad_d;
        busy_q   <= busy_d;
        locked_q <= locked_d;
        duress_q <= duress_d;
      end
    end
  assign keypad     = keypad_q;
  assign entry_busy = busy_q;
  assign locked     = locked_q;
  assign fail_cnt   = fail_q;
  assign duress     = duress_q;
endmodule

// File: tb/tb_keypad_code_entry.sv
// tb_keypad_code_entry: table-driven directed vectors plus lockout, timeout and duress sequences
module tb_keypad_code_entry;
  logic       clk = 1'b0, reset_n = 1'b0, ENA = 1'b0, key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] keypad;
  logic       entry_busy, locked, duress;
  logic [1:0] fail_cnt;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic       ena, rn, kv;
    logic [3:0] kc, kp;
    logic       busy, lock;
    logic [1:0] fail;
  } vec_t;
  vec_t tbl[$];
  keypad_code_entry dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ENA        (ENA),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .keypad     (keypad),
    .entry_busy (entry_busy),
    .locked     (locked),
    .fail_cnt   (fail_cnt),
    .duress     (duress)
  );
  always #5 clk = ~clk;
  task automatic add(input logic e, input logic rn, input logic kv, input logic [3:0] kc,
                     input logic [3:0] kp, input logic b, input logic l, input logic [1:0] f);
    vec_t v;
    v.ena = e; v.rn = rn; v.kv = kv; v.kc = kc; v.kp = kp; v.busy = b; v.lock = l; v.fail = f;
    tbl.push_back(v);
  endtask
  task automatic step(input logic e, input logic rn, input logic kv, input logic [3:0] kc);
    ENA = e; reset_n = rn; key_valid = kv; key_code = kc;
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] k);
    step(1'b1, 1'b1, 1'b1, k);
  endtask
  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 4'h0);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic entry(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic [3:0] cmd);
    press(a); press(b); press(c); press(d); press(cmd); idle();
  endtask
  initial begin
    add(1,0,0,4'h0, 4'h0,0,0,0);
    add(1,1,1,4'h1, 4'h0,1,0,0); add(1,1,1,4'h2, 4'h0,1,0,0);
    add(1,1,1,4'h3, 4'h0,1,0,0); add(1,1,1,4'h4, 4'h0,1,0,0);
    add(1,1,1,4'hA, 4'h0,1,0,0);
    add(1,1,0,4'h0, 4'h3,1,0,0); add(1,1,1,4'h5, 4'h3,1,0,0);
    add(1,1,0,4'h0, 4'h3,1,0,0); add(1,1,0,4'h0, 4'h3,1,0,0);
    add(1,1,0,4'h0, 4'h0,0,0,0);
    for (int d = 1; d <= 5; d++) add(1,1,1,4'(d), 4'h0,1,0,0);
    add(1,1,1,4'hA, 4'h0,1,0,0); add(1,1,0,4'h0, 4'h0,0,0,1);
    add(1,1,1,4'h1, 4'h0,1,0,1); add(1,1,1,4'h2, 4'h0,1,0,1); add(1,1,1,4'hC, 4'h0,0,0,1);
    for (int d = 1; d <= 4; d++) add(1,1,1,4'(d), 4'h0,1,0,1);
    add(1,1,1,4'hA, 4'h0,1,0,1);
    for (int i = 0; i < 4; i++) add(1,1,0,4'h0, 4'h3,1,0,0);
    add(1,1,0,4'h0, 4'h0,0,0,0);
    add(0,1,1,4'h1, 4'h0,0,0,0);
    add(1,1,1,4'h1, 4'h0,1,0,0); add(0,1,1,4'h9, 4'h0,1,0,0);
    add(1,1,1,4'h2, 4'h0,1,0,0); add(0,1,0,4'h0, 4'h0,1,0,0);
    add(1,1,1,4'h3, 4'h0,1,0,0); add(0,1,0,4'h0, 4'h0,1,0,0);
    add(1,1,1,4'h4, 4'h0,1,0,0); add(0,1,0,4'h0, 4'h0,1,0,0);
    add(1,1,1,4'hB, 4'h0,1,0,0); add(0,1,0,4'h0, 4'h0,1,0,0);
    add(1,1,0,4'h0, 4'hC,1,0,0); add(0,0,0,4'h0, 4'hC,1,0,0);
    add(1,1,0,4'h0, 4'hC,1,0,0); add(0,1,1,4'h1, 4'hC,1,0,0);
    add(1,1,0,4'h0, 4'hC,1,0,0); add(0,1,0,4'h0, 4'hC,1,0,0);
    add(1,1,0,4'h0, 4'hC,1,0,0); add(0,1,0,4'h0, 4'hC,1,0,0);
    add(1,1,0,4'h0, 4'h0,0,0,0);
    add(1,1,1,4'h1, 4'h0,1,0,0); add(1,1,1,4'hA, 4'h0,1,0,0);
    add(1,1,0,4'h0, 4'h0,0,0,1); add(1,0,0,4'h0, 4'h0,0,0,0);
    for (int d = 1; d <= 4; d++) add(1,1,1,4'(d), 4'h0,1,0,0);
    add(1,1,1,4'hA, 4'h0,1,0,0);
    add(1,1,0,4'h0, 4'h3,1,0,0); add(1,1,0,4'h0, 4'h3,1,0,0);
    add(1,0,0,4'h0, 4'h0,0,0,0); add(1,1,0,4'h0, 4'h0,0,0,0);
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].ena, tbl[i].rn, tbl[i].kv, tbl[i].kc);
      chk($sformatf("vec%0d keypad", i), 32'(keypad), 32'(tbl[i].kp));
      chk($sformatf("vec%0d busy", i), 32'(entry_busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].lock));
      chk($sformatf("vec%0d fail_cnt", i), 32'(fail_cnt), 32'(tbl[i].fail));
    end
    for (int r = 0; r < 3; r++) begin
      entry(4'h1, 4'h2, 4'h3, 4'h5, 4'hB);
      chk($sformatf("lock fail%0d", r), 32'(fail_cnt), 32'(r + 1));
      chk($sformatf("lock locked%0d", r), 32'(locked), 32'(r == 2));
    end
    for (int i = 0; i < 999; i++) begin
      if (i % 3 == 0) step(1'b0, 1'b1, 1'b1, 4'h1);
      if (i % 100 == 50) press(4'h1);
      else idle();
    end
    chk("lock held 999", 32'(locked), 32'd1);
    chk("lock keypad", 32'(keypad), 32'h0);
    idle();
    chk("lock released", 32'(locked), 32'd0);
    chk("lock fail cleared", 32'(fail_cnt), 32'd0);
    chk("lock keys dropped", 32'(entry_busy), 32'd0);
    entry(4'h1, 4'h2, 4'h3, 4'h4, 4'hB);
    chk("unlock disarm", 32'(keypad), 32'hC);
    for (int i = 0; i < 4; i++) idle();
    chk("unlock pulse end", 32'(keypad), 32'h0);
    press(4'h9); press(4'hA); idle();
    chk("to pre fail", 32'(fail_cnt), 32'd1);
    press(4'h1);
    for (int i = 0; i < 199; i++) idle();
    press(4'h2);
    chk("to key wins", 32'(entry_busy), 32'd1);
    for (int i = 0; i < 199; i++) idle();
    chk("to 199 busy", 32'(entry_busy), 32'd1);
    idle();
    chk("to 200 idle", 32'(entry_busy), 32'd0);
    chk("to fail kept", 32'(fail_cnt), 32'd1);
    press(4'h3); press(4'h4); press(4'hA); idle();
    chk("to short mismatch", 32'(fail_cnt), 32'd2);
    chk("to short keypad", 32'(keypad), 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    chk("dur reset", 32'(duress), 32'd0);
    entry(4'h1, 4'h2, 4'h3, 4'h5, 4'hB);
`ifdef KEYPAD_DURESS_EN
    chk("dur disarm", 32'(keypad), 32'hC);
    chk("dur flag", 32'(duress), 32'd1);
    chk("dur fail", 32'(fail_cnt), 32'd0);
    for (int i = 0; i < 4; i++) idle();
    entry(4'h1, 4'h2, 4'h3, 4'h5, 4'hA);
    chk("dur arm mismatch", 32'(fail_cnt), 32'd1);
    chk("dur arm keypad", 32'(keypad), 32'h0);
    chk("dur sticky", 32'(duress), 32'd1);
`else
    chk("dur off keypad", 32'(keypad), 32'h0);
    chk("dur off flag", 32'(duress), 32'd0);
    chk("dur off fail", 32'(fail_cnt), 32'd1);
    entry(4'h1, 4'h2, 4'h3, 4'h5, 4'hA);
    chk("dur off arm fail", 32'(fail_cnt), 32'd2);
    chk("dur off arm keypad", 32'(keypad), 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

PIN-entry front end that drives the 4-bit `keypad` command bus of the alarm controller. It collects digit strobes from a key matrix decoder and checks them against a fixed PIN when the ARM or DISARM key is pressed. On a match it emits the arm code (0011) or disarm code (1100) for a programmable number of enabled cycles. Repeated failures lock the entry block out for a fixed period.

## Interface
Parameters:
- `PIN_DIGITS`, 4: number of digits in a valid PIN (1..8).
- `PIN_CODE`, 32'h0000_1234: PIN as BCD nibbles, least significant nibble = last digit entered; only the low `4*PIN_DIGITS` bits are used.
- `TIMEOUT_CYC`, 200: number of enabled cycles without a key before a partial entry is abandoned.
- `PULSE_CYC`, 4: number of enabled cycles the command code is held on `keypad`.
- `MAX_FAILS`, 3: number of consecutive failed checks that causes lockout.
- `LOCKOUT_CYC`, 1000: lockout duration in enabled cycles.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset. It is honoured only when `ENA`=1.
- `ENA` in 1: clock enable. No state, counter or output changes while 0.
- `key_valid` in 1: one-cycle key strobe, sampled only when `ENA`=1.
- `key_code` in 4: 0–9 = digit; 4'hA = ARM; 4'hB = DISARM; 4'hC = CLEAR; 4'hD–4'hF = ignored.
- `keypad` out 4: command to the alarm controller. It is 4'b0000 when idle.
- `entry_busy` out 1: high while digits are held or a check/emit is in progress.
- `locked` out 1: high during lockout.
- `fail_cnt` out `$clog2(MAX_FAILS+1)`: consecutive failure count.
- `duress` out 1: see Configuration.

## Operation
States: `IDLE`, `COLLECT`, `CHECK`, `EMIT`, `LOCKOUT`.

- **IDLE**:
  - A digit is shifted into the buffer, `digit_cnt` becomes 1, and the block goes to COLLECT.
  - ARM, DISARM and CLEAR are ignored.
- **COLLECT**:
  - Each digit shifts left 4 bits into the buffer and increments `digit_cnt`. The count saturates at `PIN_DIGITS+1`, and that value marks overflow.
  - CLEAR empties the buffer and returns to IDLE. It is not a failure.
  - ARM or DISARM latches the command and goes to CHECK.
  - `TIMEOUT_CYC` enabled cycles without a valid key empties the buffer and returns to IDLE. It is not a failure.
- **CHECK** (one enabled cycle):
  - Match means `digit_cnt`==`PIN_DIGITS` and the buffer low bits equal `PIN_CODE`.
  - On a match: clear `fail_cnt`, load `keypad` with 0011 (ARM) or 1100 (DISARM), and go to EMIT.
  - On a mismatch: increment `fail_cnt`. If the new value equals `MAX_FAILS`, go to LOCKOUT; otherwise go to IDLE.
  - The buffer is cleared on leaving CHECK.
- **EMIT**: `keypad` is held for `PULSE_CYC` enabled cycles, then returns to 0000 as the block enters IDLE.
- **LOCKOUT**: `locked`=1 for `LOCKOUT_CYC` enabled cycles, then the block goes to IDLE with `fail_cnt` cleared.
- Key strobes during CHECK, EMIT and LOCKOUT are dropped.
- A key and a timeout expiring in the same cycle: the key wins and the timeout counter reloads.
- All counters use `$clog2` widths and never wrap.

## Timing
- All outputs are registered.
- Reset values: `keypad`=0000, `entry_busy`=0, `locked`=0, `fail_cnt`=0, `duress`=0. The state returns to IDLE, and the buffer and counters clear.
- Reset mid-operation aborts immediately, including cutting an EMIT pulse short. `keypad` reads 0000 after the reset edge.
- Command latency:
  - The ARM/DISARM key is sampled at enabled edge k, and the state becomes CHECK.
  - At enabled edge k+1, `keypad` takes the command code.
  - `keypad` stays at the code through edge k+`PULSE_CYC`.
  - At edge k+1+`PULSE_CYC`, `keypad` returns to 0000.
- `locked` rises on the edge that leaves CHECK on the final failure. It falls `LOCKOUT_CYC` enabled edges later.
- `entry_busy` is 1 in COLLECT, CHECK and EMIT.
- Cycles with `ENA`=0 do not count toward any duration.

## Configuration
- `KEYPAD_DURESS_EN` defined:
  - A DISARM whose entry equals `PIN_CODE` with its last digit replaced by (last digit + 1) mod 10 is accepted as a match and emits 1100.
  - `duress` is set on the CHECK→EMIT edge and stays set until reset.
  - The duress code with ARM is a mismatch.
- `KEYPAD_DURESS_EN` undefined: the duress code is an ordinary mismatch, and `duress` is tied to 0.

## Structure
- Package `keypad_pkg` holds:
  - the state enum;
  - key constants `KEY_ARM`, `KEY_DISARM` and `KEY_CLR`;
  - command constants `CODE_ARM`=4'b0011, `CODE_DISARM`=4'b1100 and `CODE_NONE`=4'b0000.
- Sub-module `keypad_timer`: an ENA-qualified loadable down-counter with an `expired` flag. One instance is shared by the timeout, EMIT and LOCKOUT durations, because those states are mutually exclusive.

## Test plan
- Correct PIN with ARM: after reset, keys 1,2,3,4,A → `keypad`=0011 for exactly 4 enabled cycles starting one cycle after the A strobe, then 0000; `fail_cnt`=0.
- Wrong PIN three times: keys 1,2,3,5,B ×3 → `fail_cnt` goes 1,2,3; `locked`=1 for 1000 enabled cycles; keys pressed during lockout are ignored; afterwards 1,2,3,4,B → 1100.
- Overflow and clear: keys 1,2,3,4,5,A → mismatch with `fail_cnt`=1; then 1,2,C,1,2,3,4,A → 0011 and `fail_cnt`=0.
- Timeout: keys 1,2 then 200 idle enabled cycles → IDLE, `entry_busy`=0, `fail_cnt` unchanged; then 3,4,A → mismatch.
- ENA gating and reset: toggle `ENA` at 50% during a correct entry → the pulse lasts 4 enabled cycles; assert `reset_n`=0 in mid-EMIT → `keypad`=0000 on the next enabled edge.
- With `KEYPAD_DURESS_EN`: keys 1,2,3,5,B → 1100 and `duress`=1; keys 1,2,3,5,A → mismatch.
